// File: rtl/encoder_read_scheduler.sv
// Read sequencer for the AS5600 encoder I2C master. It launches reads from a poll
// timer or on request, retries failed reads, escalates faults and holds the last good angle.
module encoder_read_scheduler #(
  parameter int POLL_PERIOD    = 50000,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int MAX_RETRIES    = 2,
  parameter int FAULT_LIMIT    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        read_req,
  input  logic        fault_clear,
  output logic        i2c_start,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [11:0] i2c_angle,
  output logic [11:0] angle,
  output logic        angle_valid,
  output logic        angle_update,
  output logic        fault,
  output logic        sched_busy,
  output logic [7:0]  nack_count,
  output logic [7:0]  timeout_count
);
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLDOFF} state_t;

  state_t          r_state, w_state_nx;
  logic [PW-1:0]   r_poll_cnt;
  logic [TW-1:0]   r_timer;
  logic [RW-1:0]   r_retry;
  logic [3:0]      r_streak;
  logic            r_pending;
  logic [11:0]     r_angle;
  logic            r_valid, r_update, r_fault;
  logic [7:0]      r_nack_cnt, r_to_cnt;

  logic w_poll_wrap, w_launch, w_success, w_fail, w_retry, w_nack_inc, w_to_inc;
  logic w_read_failed, w_fault_trip, w_fault_nx;

  assign w_poll_wrap = enable && (r_poll_cnt == PW'(POLL_PERIOD - 1));

  always_comb begin
    w_state_nx = r_state;
    w_launch   = 1'b0;
    w_success  = 1'b0;
    w_fail     = 1'b0;
    w_retry    = 1'b0;
    w_nack_inc = 1'b0;
    w_to_inc   = 1'b0;
    case (r_state)
      S_IDLE: if (r_pending && enable && !i2c_busy) begin
        w_launch   = 1'b1;
        w_state_nx = S_START;
      end
      S_START: w_state_nx = S_WAIT;
      S_WAIT: begin
        // A done landing on the timeout cycle still counts as the answer.
        if (i2c_done) begin
          if (!i2c_nack) begin
            w_success  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_nack_inc = 1'b1;
            w_fail     = 1'b1;
          end
        end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          w_to_inc = 1'b1;
          w_fail   = 1'b1;
        end
      end
      S_HOLDOFF: if (!i2c_busy) w_state_nx = S_START;
      default: w_state_nx = S_IDLE;
    endcase
    if (w_fail) begin
      if (r_retry < RW'(MAX_RETRIES)) begin
        w_retry    = 1'b1;
        w_state_nx = S_HOLDOFF;
      end else begin
        w_state_nx = S_IDLE;
      end
    end
  end

  assign w_read_failed = w_fail && !w_retry;
  assign w_fault_trip  = w_read_failed && (({1'b0, r_streak} + 5'd1) >= 5'(FAULT_LIMIT));
  assign w_fault_nx    = fault_clear ? 1'b0 : (r_fault || w_fault_trip);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_poll_cnt <= '0;
      r_pending  <= 1'b0;
      r_timer    <= '0;
      r_retry    <= '0;
    end else begin
      r_state <= w_state_nx;
      if (!enable || w_poll_wrap) r_poll_cnt <= '0;
      else                        r_poll_cnt <= r_poll_cnt + 1'b1;
      // New requests win over the launch clear so none is dropped.
      if (w_poll_wrap || read_req) r_pending <= 1'b1;
      else if (w_launch)           r_pending <= 1'b0;
      if (r_state == S_START)     r_timer <= '0;
      else if (r_state == S_WAIT) r_timer <= r_timer + 1'b1;
      if (w_launch)     r_retry <= '0;
      else if (w_retry) r_retry <= r_retry + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_angle    <= '0;
      r_valid    <= 1'b0;
      r_update   <= 1'b0;
      r_fault    <= 1'b0;
      r_streak   <= '0;
      r_nack_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_update <= w_success;
      r_fault  <= w_fault_nx;
      if (w_success) begin
        r_angle <= i2c_angle;
        r_valid <= !w_fault_nx;
      end else if (w_fault_trip) begin
        r_valid <= 1'b0;
      end
      if (fault_clear || w_success)                r_streak <= '0;
      else if (w_read_failed && r_streak != 4'hF) r_streak <= r_streak + 1'b1;
      if (fault_clear)                             r_nack_cnt <= '0;
      else if (w_nack_inc && r_nack_cnt != 8'hFF) r_nack_cnt <= r_nack_cnt + 1'b1;
      if (fault_clear)                             r_to_cnt <= '0;
      else if (w_to_inc && r_to_cnt != 8'hFF)     r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign i2c_start     = (r_state == S_START);
  assign sched_busy    = (r_state != S_IDLE);
  assign angle         = r_angle;
  assign angle_valid   = r_valid;
  assign angle_update  = r_update;
  assign fault         = r_fault;
  assign nack_count    = r_nack_cnt;
  assign timeout_count = r_to_cnt;
endmodule

// File: doc/encoder_read_scheduler.md
Name: encoder_read_scheduler

Overview:
Sequences the encoder I2C master that reads the AS5600 12-bit raw angle. Issues read transactions either periodically from an internal poll timer or on demand from the PWM controller. Handles timeout, NACK retry and fault escalation, and holds the last good angle for the PWM control loop. Sits between the PWM controller logic and the I2C master.

Parameters:
POLL_PERIOD, 50000, clock cycles between automatic reads (1 kHz at 50 MHz); legal range ≥ 2
TIMEOUT_CYCLES, 20000, cycles from i2c_start without i2c_done before a timeout is declared; legal range ≥ 2
MAX_RETRIES, 2, extra attempts after a failed transaction before the read counts as failed
FAULT_LIMIT, 3, consecutive failed reads that set fault; legal range 1..15

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  allows the poll timer to run and new transactions to start
read_req  input  1  single-cycle on-demand read request
fault_clear  input  1  single-cycle pulse; clears fault, fail streak and error counters
i2c_start  output  1  single-cycle pulse to the I2C master to start one angle read
i2c_busy  input  1  I2C master is mid-transaction
i2c_done  input  1  single-cycle pulse; the transaction has finished
i2c_nack  input  1  qualifies i2c_done: the slave NACKed
i2c_angle  input  12  angle from the I2C master, valid with i2c_done
angle  output  12  last good angle
angle_valid  output  1  angle is current; no fault
angle_update  output  1  single-cycle pulse when angle is updated
fault  output  1  sticky fault flag
sched_busy  output  1  FSM is not in IDLE
nack_count  output  8  saturating count of NACKed attempts
timeout_count  output  8  saturating count of timed-out attempts

Behaviour:
- Reset values: all outputs 0. FSM is in IDLE. The poll counter, pending flag, retry count and fail streak are 0.
- Poll counter:
  - Counts 0..POLL_PERIOD-1 while enable=1.
  - At POLL_PERIOD-1 it wraps to 0 and sets pending.
  - Held at 0 while enable=0.
- read_req sets pending, including when enable=0. A request made while pending is already set is merged into the existing one (no queue). A read_req pulse is not lost while the FSM is busy.
- FSM states: IDLE, START, WAIT, HOLDOFF.
- IDLE:
  - When pending & enable & !i2c_busy: clear pending, set retry_cnt=0, go to START.
- START:
  - i2c_start=1 for exactly this cycle.
  - Clear the timeout timer and go to WAIT.
  - Latency from the qualifying IDLE cycle to the i2c_start pulse: 1 cycle.
- WAIT: timer increments every cycle.
  - i2c_done & !i2c_nack:
    - angle<=i2c_angle.
    - angle_valid<=!fault_next; the angle is still captured if fault is set.
    - angle_update=1 on the following cycle.
    - fail_streak<=0.
    - Go to IDLE.
  - i2c_done & i2c_nack: nack_count++ (saturates at 255), then take the failure path.
  - Timer reaches TIMEOUT_CYCLES-1 with no i2c_done: timeout_count++ (saturates at 255), then take the failure path.
  - i2c_done and timeout in the same cycle: i2c_done wins and no timeout is counted.
- Failure path:
  - If retry_cnt<MAX_RETRIES: retry_cnt++, go to HOLDOFF.
  - Otherwise: fail_streak++ (saturates at 15), go to IDLE.
  - If fail_streak+1 ≥ FAULT_LIMIT: fault<=1 and angle_valid<=0.
- HOLDOFF: waits until i2c_busy=0, then goes to START. Retries ignore enable.
- Deasserting enable mid-transaction does not abort: the current read and its retries complete, then the FSM stays in IDLE.
- fault is sticky. It is cleared only by reset or fault_clear.
- fault_clear:
  - Zeroes fault, fail_streak, nack_count and timeout_count in the next cycle.
  - Does not touch angle or the FSM.
  - angle_valid stays 0 until the next good read.
- If fault_clear coincides with a counter increment, the clear wins.
- sched_busy = (state != IDLE).
- i2c_done arriving in IDLE, START or HOLDOFF is ignored.

Test Plan:
Bench uses POLL_PERIOD=100, TIMEOUT_CYCLES=20, MAX_RETRIES=2, FAULT_LIMIT=3.
1. Reset, enable=1, model returns done with angle 12'hABC 10 cycles after start -> i2c_start about every 100 cycles; angle=0xABC, angle_valid=1, one angle_update pulse per read.
2. enable=0, pulse read_req, then enable=1 -> exactly one i2c_start 1 cycle after the first cycle in which enable=1 and i2c_busy=0. A second read_req during WAIT produces exactly one further read.
3. Model NACKs twice, then returns done with 0x123 -> 3 i2c_start pulses; nack_count=2; angle=0x123, angle_valid=1; fault=0.
4. Model never responds -> per read, 3 attempts each 20 cycles apart plus holdoff. After 3 failed reads: timeout_count=9, fault=1, angle_valid=0. fault_clear -> fault=0 and counters=0.
5. i2c_done on the same cycle the timer reaches 19 -> treated as success; timeout_count unchanged.
6. Assert reset during WAIT -> all outputs 0 next cycle; a late i2c_done is ignored; polling resumes cleanly after reset is released.
